fetch_unit: RTL

//  IF stage of the RV32I pipeline: owns the PC and issues word reads to instruction memory.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I types and constants for the fetch stage
package riscv_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {instr, pc} entries; flush overrides push/pop
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem [DEPTH];
    logic [IW-1:0] rd_ptr;
    logic [IW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(DEPTH - 1)) ? '0 : p + IW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC, credit-limited imem reads, prefetch buffer, redirect drain
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            clr_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    input  logic            dec_ready
);
    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    fetch_state_e    state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic [XLEN-1:0] redirect_target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   drop_reload;
    logic [CW-1:0]   fifo_count;
    logic [1:0]      sync_q;
    logic            clr_n_sync;
    logic            credit;
    logic            fire;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            fifo_full;
    fetch_entry_t    fifo_head;
    fetch_entry_t    push_entry;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], 1'b1};
    end
    assign clr_n_sync = sync_q[1];

    // Reads in flight plus buffered entries never exceed the FIFO size, so every response has a slot.
    assign credit         = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_W;
    assign imem_req_valid = clr_n_sync & ~redirect & credit;
    assign imem_req_addr  = pc_q;
    assign fire           = imem_req_valid & imem_req_ready;

    assign push       = imem_rsp_valid & ~redirect & (state == FETCH);
    assign push_entry = '{instr: imem_rsp_data, pc: rsp_pc_q};

    assign instr_valid    = ~fifo_empty & ~redirect;
    assign pop            = instr_valid & dec_ready;
    assign instr          = fifo_empty ? NOP_INSTR : fifo_head.instr;
    assign instr_pc       = fifo_empty ? rsp_pc_q : fifo_head.pc;
    assign instr_pc_plus4 = instr_pc + XLEN'(4);

    assign redirect_target = word_align(redirect_pc);
    assign drop_reload     = outstanding - CW'(imem_rsp_valid);

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .clr_n     (clr_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pc_q        <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            state       <= FETCH;
        end else begin
            outstanding <= outstanding + CW'(fire) - CW'(imem_rsp_valid);
            if (redirect) begin
                pc_q     <= redirect_target;
                rsp_pc_q <= redirect_target;
                drop_cnt <= drop_reload;
                state    <= (drop_reload != '0) ? DRAIN : FETCH;
            end else begin
                if (fire) pc_q <= pc_q + XLEN'(4);
                if (imem_rsp_valid) begin
                    case (state)
                        FETCH: rsp_pc_q <= rsp_pc_q + XLEN'(4);
                        DRAIN: begin
                            drop_cnt <= drop_cnt - CW'(1);
                            if (drop_cnt == CW'(1)) state <= FETCH;
                        end
                        default: state <= FETCH;
                    endcase
                end
            end
        end
    end

    a_fifo_overflow: assert property (@(posedge clk) disable iff (!clr_n)
        !(push && fifo_full && !pop));
    a_outstanding_range: assert property (@(posedge clk) disable iff (!clr_n)
        !(imem_rsp_valid && outstanding == '0) &&
        !(fire && !imem_rsp_valid && outstanding == CW'(FIFO_DEPTH)));
    a_drop_range: assert property (@(posedge clk) disable iff (!clr_n)
        !(state == DRAIN && drop_cnt == '0));

endmodule
